// File: rtl/mips_avalon_pkg.sv
// Shared types for the MIPS Avalon arbiter: FSM states, grant encodings and the
// master-side request bundle.
package mips_avalon_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGntI = 2'd1,
    StGntD = 2'd2
  } arb_state_e;

  localparam logic [1:0] GrantNone  = 2'b00;
  localparam logic [1:0] GrantInstr = 2'b01;
  localparam logic [1:0] GrantData  = 2'b10;

  localparam logic LastInstr = 1'b0;
  localparam logic LastData  = 1'b1;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } avalon_req_t;

endpackage

// File: rtl/mips_rr_arbiter2.sv
// Two-input round-robin picker; on a tie the port not granted last time wins.
module mips_rr_arbiter2
  import mips_avalon_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic req_d,
  input  logic take,
  output logic pick_i,
  output logic pick_d
);

  logic last_grant_q;

  always_comb begin
    pick_i = req_i;
    pick_d = req_d;
    if (req_i && req_d) begin
      pick_i = (last_grant_q == LastData);
      pick_d = (last_grant_q == LastInstr);
    end
  end

  // Resetting to data lets the instruction master win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= LastData;
    end else if (take && (pick_i || pick_d)) begin
      last_grant_q <= pick_d ? LastData : LastInstr;
    end
  end

endmodule

// File: rtl/mips_avalon_arbiter.sv
// Shares one Avalon slave between the instruction-fetch and data masters, one
// transaction per grant with a forced idle cycle in between; flags long stalls.
module mips_avalon_arbiter
  import mips_avalon_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  arb_state_e  state_q;
  logic [1:0]  grant_q;
  logic [31:0] stall_cnt_q;
  logic        timeout_err_q;

  logic        req_i, req_d, pick_i, pick_d, cur_req, stall_hit;
  logic [31:0] stall_next;
  avalon_req_t i_req, d_req, m_req;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  mips_rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_i  (req_i),
    .req_d  (req_d),
    .take   (state_q == StIdle),
    .pick_i (pick_i),
    .pick_d (pick_d)
  );

  assign i_req = '{address: i_address, read: i_read, write: 1'b0, writedata: 32'h0,
                   byteenable: 4'hF};
  assign d_req = '{address: d_address, read: d_read, write: d_write, writedata: d_writedata,
                   byteenable: d_byteenable};

  assign cur_req    = (state_q == StGntI) ? req_i : req_d;
  assign stall_next = (stall_cnt_q == 32'hFFFF_FFFF) ? stall_cnt_q : stall_cnt_q + 32'd1;
  assign stall_hit  = (TIMEOUT != 0) && (stall_next == 32'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= GrantNone;
      stall_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          stall_cnt_q <= '0;
          if (pick_i) begin
            state_q <= StGntI;
            grant_q <= GrantInstr;
          end else if (pick_d) begin
            state_q <= StGntD;
            grant_q <= GrantData;
          end
        end
        StGntI, StGntD: begin
          if (m_waitrequest) begin
            stall_cnt_q <= stall_next;
            if (stall_hit) timeout_err_q <= 1'b1;
          end
          // Completion or a dropped request both return to idle; no abort on timeout.
          if (!cur_req || !m_waitrequest) begin
            state_q <= StIdle;
            grant_q <= GrantNone;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= GrantNone;
        end
      endcase
    end
  end

  always_comb begin
    m_req         = '0;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = 32'h0;
    d_readdata    = 32'h0;
    unique case (state_q)
      StGntI: begin
        m_req         = i_req;
        i_waitrequest = m_waitrequest;
        i_readdata    = m_readdata;
      end
      StGntD: begin
        m_req         = d_req;
        d_waitrequest = m_waitrequest;
        d_readdata    = m_readdata;
      end
      default: ;
    endcase
  end

  assign m_address    = m_req.address;
  assign m_read       = m_req.read;
  assign m_write      = m_req.write;
  assign m_writedata  = m_req.writedata;
  assign m_byteenable = m_req.byteenable;
  assign grant        = grant_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Scoreboarded bench: two master processes, a delay-programmable slave model and a
// transaction-level memory model predicting read data and write effects.
module tb_mips_avalon_arbiter;
  import mips_avalon_pkg::*;

  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0;
  logic        i_read = 1'b0;
  logic        i_waitrequest;
  logic [31:0] i_readdata;
  logic [31:0] d_address = '0;
  logic        d_read = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_writedata = '0;
  logic [3:0]  d_byteenable = '0;
  logic        d_waitrequest;
  logic [31:0] d_readdata;
  logic [31:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic [1:0]  grant;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.TIMEOUT(Timeout)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_waitrequest (i_waitrequest),
    .i_readdata    (i_readdata),
    .d_address     (d_address),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_writedata   (d_writedata),
    .d_byteenable  (d_byteenable),
    .d_waitrequest (d_waitrequest),
    .d_readdata    (d_readdata),
    .m_address     (m_address),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_byteenable  (m_byteenable),
    .m_waitrequest (m_waitrequest),
    .m_readdata    (m_readdata),
    .grant         (grant),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: waitrequest held for slave_delay cycles of each transaction.
  logic [31:0] slave_mem [64];
  logic [31:0] ref_mem   [64];
  int unsigned slave_delay = 0;
  int unsigned slave_cnt = 0;
  logic        force_wait = 1'b0;
  bit          mem_loaded = 1'b0;

  assign m_waitrequest = force_wait || ((m_read || m_write) && (slave_cnt < slave_delay));
  assign m_readdata    = m_read ? slave_mem[m_address[7:2]] : 32'h0;

  always @(posedge clk or posedge reset) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 64; k++) slave_mem[k] <= ref_mem[k];
      mem_loaded <= 1'b1;
    end
    if (reset) begin
      slave_cnt <= 0;
    end else begin
      slave_cnt <= (m_read || m_write) ? slave_cnt + 1 : 0;
      if (m_write && !m_waitrequest && mem_loaded)
        for (int b = 0; b < 4; b++)
          if (m_byteenable[b]) slave_mem[m_address[7:2]][8*b +: 8] <= m_writedata[8*b +: 8];
    end
  end

  // Scoreboard queues, filled at issue time from the memory model.
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  avalon_req_t exp_w_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (i_read && !i_waitrequest) begin
        if (exp_i_q.size() == 0) check("i_readdata unexpected completion", 1, 0);
        else check("i_readdata", i_readdata, exp_i_q.pop_front());
      end
      if (d_read && !d_waitrequest) begin
        if (exp_d_q.size() == 0) check("d_readdata unexpected completion", 1, 0);
        else check("d_readdata", d_readdata, exp_d_q.pop_front());
      end
      if (m_write && !m_waitrequest) begin
        if (exp_w_q.size() == 0) check("write unexpected", 1, 0);
        else begin
          avalon_req_t w;
          w = exp_w_q.pop_front();
          check("m_address write", m_address, w.address);
          check("m_writedata", m_writedata, w.writedata);
          check("m_byteenable write", m_byteenable, w.byteenable);
        end
      end
      if (grant == 2'b01) begin
        check("d side blocked in GNT_I", {d_waitrequest, d_readdata}, {1'b1, 32'h0});
        check("instr forward", {m_write, m_byteenable, m_address}, {1'b0, 4'hF, i_address});
      end
      if (grant == 2'b10)
        check("i side blocked in GNT_D", {i_waitrequest, i_readdata}, {1'b1, 32'h0});
      if (grant == 2'b00)
        check("idle outputs", {m_read, m_write, m_address, i_waitrequest, d_waitrequest},
              {1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
    end
  end

  // Grant sequence log with the idle-run length seen before each grant.
  logic [1:0] grant_log[$];
  int         gap_log[$];
  logic [1:0] prev_grant = 2'b00;
  int         idle_run = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (grant != 2'b00 && prev_grant == 2'b00) begin
        grant_log.push_back(grant);
        gap_log.push_back(idle_run);
      end
      idle_run <= (grant == 2'b00) ? idle_run + 1 : 0;
    end else begin
      idle_run <= 0;
    end
    prev_grant <= reset ? 2'b00 : grant;
  end

  task automatic wait_done(input bit is_d, output int hold, output bit ok);
    bit done = 1'b0;
    hold = 0;
    while (!done && hold < 200) begin
      @(negedge clk);
      done = is_d ? !d_waitrequest : !i_waitrequest;
      @(posedge clk);
      #1;
      hold++;
    end
    ok = done;
  endtask

  task automatic instr_txn(input logic [31:0] addr, output int hold);
    bit ok;
    i_address = addr;
    i_read    = 1'b1;
    exp_i_q.push_back(ref_mem[addr[7:2]]);
    wait_done(1'b0, hold, ok);
    i_read = 1'b0;
    check("instr txn completes", ok, 1);
  endtask

  task automatic data_txn(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                          input logic [3:0] be, output int hold);
    bit ok;
    d_address    = addr;
    d_read       = !wr;
    d_write      = wr;
    d_writedata  = wdata;
    d_byteenable = be;
    if (wr) begin
      exp_w_q.push_back('{address: addr, read: 1'b0, write: 1'b1, writedata: wdata,
                          byteenable: be});
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
    end else begin
      exp_d_q.push_back(ref_mem[addr[7:2]]);
    end
    wait_done(1'b1, hold, ok);
    d_read  = 1'b0;
    d_write = 1'b0;
    check("data txn completes", ok, 1);
  endtask

  task automatic instr_stream(input int n, input int max_gap);
    int h;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      instr_txn(32'hBFC0_0000 | (32'($urandom_range(0, 31)) << 2), h);
    end
  endtask

  task automatic data_stream(input int n, input int max_gap);
    int h;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      data_txn(32'h0000_0080 | (32'($urandom_range(0, 31)) << 2), 1'($urandom_range(0, 1)),
               $urandom, 4'($urandom_range(1, 15)), h);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h;
    for (int k = 0; k < 64; k++) ref_mem[k] = $urandom;
    #1;
    check("reset grant", grant, 2'b00);
    check("reset m_read/m_write", {m_read, m_write}, 2'b00);
    check("reset waitrequests", {i_waitrequest, d_waitrequest}, 2'b11);
    check("reset timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Solo instruction read, slave delay 2.
    slave_delay = 2;
    fork
      instr_txn(32'hBFC0_0000, h);
      begin
        @(negedge clk);
        check("solo grant request cycle", grant, 2'b00);
        @(negedge clk);
        check("solo grant next cycle", grant, 2'b01);
      end
    join
    check("solo instr hold cycles", h, 4);
    @(negedge clk);
    check("solo idle after completion", grant, 2'b00);

    // Tie straight after reset: instruction first, then the data write.
    do_reset();
    grant_log.delete();
    fork
      instr_txn(32'hBFC0_0004, h);
      data_txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'b0011, h);
    join
    check("tie grant count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("tie first grant", grant_log[0], 2'b01);
      check("tie second grant", grant_log[1], 2'b10);
    end
    @(posedge clk);
    #1;
    check("memory[4] low halfword", slave_mem[4][15:0], 16'hBEEF);
    data_txn(32'h0000_0010, 1'b0, 32'h0, 4'h0, h);

    // Continuous contention: strict alternation with one idle cycle per handover.
    slave_delay = 1;
    @(posedge clk);
    #1;
    grant_log.delete();
    gap_log.delete();
    fork
      instr_stream(3, 0);
      data_stream(3, 0);
    join
    check("alternation grant count", grant_log.size(), 6);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      check("alternation order", grant_log[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) check("alternation idle gap", gap_log[k], 1);
    end

    // Zero-delay slave: completion in the first granted cycle.
    slave_delay = 0;
    @(posedge clk);
    #1;
    data_txn(32'h0000_0008, 1'b0, 32'h0, 4'h0, h);
    check("zero delay hold cycles", h, 2);

    // Randomised traffic across slave delays.
    for (int p = 0; p < 3; p++) begin
      slave_delay = $urandom_range(0, 3);
      fork
        instr_stream(12, 2);
        data_stream(12, 2);
      join
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) check("memory contents", slave_mem[k], ref_mem[k]);
    check("scoreboard drained", exp_i_q.size() + exp_d_q.size() + exp_w_q.size(), 0);
    check("no timeout on normal traffic", timeout_err, 0);

    // Stuck slave: error after Timeout stalled cycles, sticky afterwards.
    do_reset();
    slave_delay = 0;
    force_wait = 1'b1;
    fork
      instr_txn(32'hBFC0_0010, h);
      begin
        int n = 0;
        @(negedge clk);
        while (grant != 2'b01 && n < 20) begin @(negedge clk); n++; end
        check("timeout test grant", grant, 2'b01);
        repeat (Timeout - 1) @(negedge clk);
        check("timeout_err before limit", timeout_err, 0);
        @(negedge clk);
        check("timeout_err at limit", timeout_err, 1);
        @(posedge clk);
        #1;
        force_wait = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    check("timeout_err sticky", timeout_err, 1);

    // Reset in the middle of a data grant.
    @(posedge clk);
    #1;
    slave_delay  = 3;
    d_address    = 32'h0000_0084;
    d_writedata  = 32'h1234_5678;
    d_byteenable = 4'hF;
    d_write      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mid reset grant before", grant, 2'b10);
    check("mid reset m_write before", m_write, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid reset m_write drop", m_write, 0);
    check("mid reset m_address", m_address, 0);
    check("mid reset d_waitrequest", d_waitrequest, 1);
    check("mid reset grant", grant, 2'b00);
    d_write = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("after reset grant", grant, 2'b00);
    check("after reset timeout_err", timeout_err, 0);
    check("after reset memory untouched", slave_mem[33], ref_mem[33]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
